// File: rtl/tw_core_pkg.sv
// -----------------------------------------------------------------------------
// tw_core_pkg -- shared types for the tw_core accumulator machine.
//   opcode_e : 4-bit instruction opcodes
//   state_e  : control FSM states (FETCH / EXEC / HALT)
//   is_add() : true for the three opcodes whose carry-out lands in C
// -----------------------------------------------------------------------------
package tw_core_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD_A_IMM = 4'b0000,
    OP_MOV_A_B   = 4'b0001,
    OP_IN_A      = 4'b0010,
    OP_LDI_A     = 4'b0011,
    OP_MOV_B_A   = 4'b0100,
    OP_ADD_B_IMM = 4'b0101,
    OP_IN_B      = 4'b0110,
    OP_LDI_B     = 4'b0111,
    OP_ADD_A_B   = 4'b1000,
    OP_OUT_B     = 4'b1001,
    OP_HALT      = 4'b1010,
    OP_OUT_IMM   = 4'b1011,
    OP_JC        = 4'b1100,
    OP_NOP       = 4'b1101,
    OP_JMP       = 4'b1110,
    OP_JNC       = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  function automatic logic is_add(opcode_e op);
    return op inside {OP_ADD_A_IMM, OP_ADD_B_IMM, OP_ADD_A_B};
  endfunction

endpackage

// File: rtl/tw_core_if.sv
// -----------------------------------------------------------------------------
// tw_core_if -- instruction-fetch and I/O bundle of tw_core.
//   o_addr / o_fetch_req        : program counter and fetch request to the ROM
//   i_instr / i_instr_valid     : instruction {opcode, imm} and its valid flag
//   i_in                        : general input port
//   o_out / o_out_valid         : registered output port and one-cycle strobe
//   o_halted                    : core is parked in HALT
// Direction prefixes are from the core's point of view.
//   master : the core        slave : the environment (ROM, I/O, bench)
// -----------------------------------------------------------------------------
interface tw_core_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]   o_addr;
  logic                o_fetch_req;
  logic [DATA_W+3:0]   i_instr;
  logic                i_instr_valid;
  logic [DATA_W-1:0]   i_in;
  logic [DATA_W-1:0]   o_out;
  logic                o_out_valid;
  logic                o_halted;

  modport master (
    output o_addr, o_fetch_req, o_out, o_out_valid, o_halted,
    input  i_instr, i_instr_valid, i_in
  );

  modport slave (
    input  o_addr, o_fetch_req, o_out, o_out_valid, o_halted,
    output i_instr, i_instr_valid, i_in
  );
endinterface

// File: rtl/tw_alu.sv
// -----------------------------------------------------------------------------
// tw_alu -- DATA_W-bit adder with carry-out, shared by all add opcodes.
//   i_a, i_b : operands
//   o_sum    : low DATA_W bits of i_a + i_b
//   o_carry  : bit DATA_W of the (DATA_W+1)-bit sum
// -----------------------------------------------------------------------------
module tw_alu #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/tw_core.sv
// -----------------------------------------------------------------------------
// tw_core -- two-register (A, B) accumulator core with carry flag C.
// Each instruction takes a FETCH phase (waits for i_instr_valid, may stall)
// and exactly one EXEC cycle. HALT parks the core until reset.
//   clock : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : tw_core_if.master (fetch handshake, in/out ports, halted)
// -----------------------------------------------------------------------------
module tw_core
  import tw_core_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  tw_core_if.master  bus
);

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_pc, w_pc_next;
  logic [DATA_W-1:0]   r_a, w_a_next;
  logic [DATA_W-1:0]   r_b, w_b_next;
  logic                r_c, w_c_next;
  logic [DATA_W+3:0]   r_ir, w_ir_next;
  logic [DATA_W-1:0]   r_out, w_out_next;
  logic                r_out_valid, w_out_valid_next;

  opcode_e             w_op;
  logic [DATA_W-1:0]   w_imm;
  logic [ADDR_W-1:0]   w_target;
  logic [DATA_W-1:0]   w_alu_a, w_alu_b, w_sum;
  logic                w_carry;

  assign w_op     = opcode_e'(r_ir[DATA_W+3:DATA_W]);
  assign w_imm    = r_ir[DATA_W-1:0];
  assign w_target = r_ir[ADDR_W-1:0];

  // One adder serves A+imm, B+imm and A+B.
  assign w_alu_a = (w_op == OP_ADD_B_IMM) ? r_b : r_a;
  assign w_alu_b = (w_op == OP_ADD_A_B)   ? r_b : w_imm;

  tw_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a     (w_alu_a),
    .i_b     (w_alu_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_comb begin
    // NOTE: every target gets its hold value first, so no branch can infer a latch.
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_a_next         = r_a;
    w_b_next         = r_b;
    w_c_next         = r_c;
    w_ir_next        = r_ir;
    w_out_next       = r_out;
    w_out_valid_next = 1'b0;

    case (r_state)
      ST_FETCH: begin
        if (bus.i_instr_valid) begin
          w_ir_next    = bus.i_instr;
          w_state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        w_state_next = ST_FETCH;
        w_pc_next    = r_pc + ADDR_W'(1);
        // Jumps below read r_c, i.e. C as it stood before this instruction.
        w_c_next     = is_add(w_op) ? w_carry : 1'b0;
        case (w_op)
          OP_ADD_A_IMM,
          OP_ADD_A_B:   w_a_next = w_sum;
          OP_MOV_A_B:   w_a_next = r_b;
          OP_IN_A:      w_a_next = bus.i_in;
          OP_LDI_A:     w_a_next = w_imm;
          OP_MOV_B_A:   w_b_next = r_a;
          OP_ADD_B_IMM: w_b_next = w_sum;
          OP_IN_B:      w_b_next = bus.i_in;
          OP_LDI_B:     w_b_next = w_imm;
          OP_OUT_B: begin
            w_out_next       = r_b;
            w_out_valid_next = 1'b1;
          end
          OP_OUT_IMM: begin
            w_out_next       = w_imm;
            w_out_valid_next = 1'b1;
          end
          OP_HALT: begin
            w_pc_next    = r_pc;
            w_state_next = ST_HALT;
          end
          OP_JC:        if (r_c)  w_pc_next = w_target;
          OP_JNC:       if (!r_c) w_pc_next = w_target;
          OP_JMP:       w_pc_next = w_target;
          default:      ;  // NOP
        endcase
      end

      ST_HALT: ;  // everything frozen until reset

      default: w_state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking so every register samples pre-edge values of its peers.
    if (!reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
      r_ir        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_a         <= w_a_next;
      r_b         <= w_b_next;
      r_c         <= w_c_next;
      r_ir        <= w_ir_next;
      r_out       <= w_out_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  assign bus.o_addr      = r_pc;
  assign bus.o_fetch_req = (r_state == ST_FETCH);
  assign bus.o_halted    = (r_state == ST_HALT);
  assign bus.o_out       = r_out;
  assign bus.o_out_valid = r_out_valid;

endmodule

// File: tb/tb_tw_core.sv
// -----------------------------------------------------------------------------
// tb_tw_core -- scoreboard bench for tw_core (DATA_W=4, ADDR_W=4).
// A driver walks each program with an instruction-level reference model,
// pushing the expected per-cycle view (fetch_req, halted, addr, out,
// out_valid) and every expected out write into queues; a negedge monitor
// pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_tw_core;
  localparam int DW = 4;
  localparam int AW = 4;

  typedef struct {
    bit fetch_req;
    bit halted;
    int addr;
    int out;
    bit out_valid;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b0;

  tw_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  tw_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t st_q[$];
  int   out_q[$];
  bit   obs_en = 1'b0;

  logic [7:0] rom [16];

  // Reference machine state.
  int m_pc, m_a, m_b, m_c, m_out;
  bit m_ov;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    if (obs_en) begin
      if (st_q.size() == 0) check("state_queue_underrun", 1, 0);
      else begin
        e = st_q.pop_front();
        check("fetch_req", int'(bus.o_fetch_req), int'(e.fetch_req));
        check("halted",    int'(bus.o_halted),    int'(e.halted));
        check("addr",      int'(bus.o_addr),      e.addr);
        check("out_hold",  int'(bus.o_out),       e.out);
        check("out_valid", int'(bus.o_out_valid), int'(e.out_valid));
      end
    end
    if (bus.o_out_valid) begin
      if (out_q.size() == 0) check("unexpected_out_write", 1, 0);
      else check("out_data", int'(bus.o_out), out_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_ov = 1'b0;
  endtask

  task automatic push_state(input bit fr, input bit hl);
    exp_t e;
    e.fetch_req = fr;
    e.halted    = hl;
    e.addr      = m_pc;
    e.out       = m_out;
    e.out_valid = m_ov;
    st_q.push_back(e);
    m_ov = 1'b0;
  endtask

  task automatic model_exec(input logic [7:0] ins, input int vin, output bit hlt);
    int op, imm, sum, npc, nc;
    op  = int'(ins[7:4]);
    imm = int'(ins[3:0]);
    npc = (m_pc + 1) % (1 << AW);
    nc  = 0;
    hlt = 1'b0;
    case (op)
      0:  begin sum = m_a + imm; m_a = sum % (1 << DW); nc = sum >> DW; end
      1:  m_a = m_b;
      2:  m_a = vin;
      3:  m_a = imm;
      4:  m_b = m_a;
      5:  begin sum = m_b + imm; m_b = sum % (1 << DW); nc = sum >> DW; end
      6:  m_b = vin;
      7:  m_b = imm;
      8:  begin sum = m_a + m_b; m_a = sum % (1 << DW); nc = sum >> DW; end
      9:  begin m_out = m_b; m_ov = 1'b1; out_q.push_back(m_b); end
      10: begin hlt = 1'b1; npc = m_pc; end
      11: begin m_out = imm; m_ov = 1'b1; out_q.push_back(imm); end
      12: if (m_c != 0) npc = imm % (1 << AW);
      14: npc = imm % (1 << AW);
      15: if (m_c == 0) npc = imm % (1 << AW);
      default: ;
    endcase
    m_c  = nc;
    m_pc = npc;
  endtask

  // ---------------- driver ----------------
  // Entry/exit point of every task: 1 time unit after a rising edge.
  task automatic step_instr(input int stalls, output bit hlt);
    logic [7:0] ins;
    int vin;
    ins = rom[m_pc];
    for (int s = 0; s <= stalls; s++) begin
      push_state(1'b1, 1'b0);
      bus.i_instr       = ins;
      bus.i_instr_valid = (s == stalls);
      bus.i_in          = 4'($urandom);
      @(posedge clock); #1;
    end
    // EXEC cycle: instr_valid is noise here and must be ignored.
    push_state(1'b0, 1'b0);
    vin = int'($urandom_range(0, 15));
    bus.i_in          = 4'(vin);
    bus.i_instr       = 8'($urandom);
    bus.i_instr_valid = 1'($urandom_range(0, 1));
    model_exec(ins, vin, hlt);
    @(posedge clock); #1;
  endtask

  task automatic run_prog(input int max_instr);
    bit hlt;
    int n;
    hlt = 1'b0;
    n   = 0;
    obs_en = 1'b1;
    while (!hlt && n < max_instr) begin
      step_instr((n == 1) ? 5 : int'($urandom_range(0, 2)), hlt);
      n++;
    end
    if (hlt) begin
      for (int k = 0; k < 10; k++) begin
        push_state(1'b0, 1'b1);
        bus.i_instr_valid = 1'($urandom_range(0, 1));
        bus.i_instr       = 8'($urandom);
        bus.i_in          = 4'($urandom);
        @(posedge clock); #1;
      end
    end
    obs_en = 1'b0;
  endtask

  task automatic do_reset();
    obs_en = 1'b0;
    bus.i_instr_valid = 1'b0;
    @(posedge clock); #1;  // let a trailing out strobe drain to the monitor
    check("pending_out_writes", out_q.size(), 0);
    check("pending_states", st_q.size(), 0);
    out_q.delete();
    st_q.delete();
    rst = 1'b0;
    @(posedge clock); #1;
    check("rst_addr",      int'(bus.o_addr),      0);
    check("rst_fetch_req", int'(bus.o_fetch_req), 1);
    check("rst_halted",    int'(bus.o_halted),    0);
    check("rst_out",       int'(bus.o_out),       0);
    check("rst_out_valid", int'(bus.o_out_valid), 0);
    @(posedge clock); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  // ---------------- main ----------------
  initial begin
    bus.i_instr = '0;
    bus.i_instr_valid = 1'b0;
    bus.i_in = '0;
    model_reset();
    @(posedge clock); #1;

    // A=5; A+=12 -> A=1,C=1; JNC not taken; B=A; OUT B; A+=15 -> C=1; JC 8; OUT 6.
    fill_rom(8'hD0);
    rom[0] = 8'h35; rom[1] = 8'h0C; rom[2] = 8'hF4; rom[3] = 8'h40;
    rom[4] = 8'h90; rom[5] = 8'h0F; rom[6] = 8'hC8; rom[7] = 8'hA0;
    rom[8] = 8'hB6; rom[9] = 8'hA0;
    do_reset();
    run_prog(20);

    // B=3; OUT B; NOPs; HALT -> single pulse, out holds 3.
    fill_rom(8'hD0);
    rom[0] = 8'h73; rom[1] = 8'h90; rom[4] = 8'hA0;
    do_reset();
    run_prog(20);

    // PC wrap: JMP 15, NOP at 15 wraps to 0.
    fill_rom(8'hD0);
    rom[0] = 8'hEF;
    do_reset();
    run_prog(6);

    // HALT at addr 2 after an OUT imm.
    fill_rom(8'hD0);
    rom[1] = 8'hBA; rom[2] = 8'hA0;
    do_reset();
    run_prog(20);

    // Reset during EXEC of A=9: nothing may be written.
    fill_rom(8'hD0);
    rom[0] = 8'h39;
    do_reset();
    bus.i_instr = rom[0];
    bus.i_instr_valid = 1'b1;
    @(posedge clock); #1;
    bus.i_instr_valid = 1'b0;
    rst = 1'b0;
    @(posedge clock); #1;
    check("midexec_rst_addr",      int'(bus.o_addr),      0);
    check("midexec_rst_fetch_req", int'(bus.o_fetch_req), 1);
    check("midexec_rst_halted",    int'(bus.o_halted),    0);
    @(posedge clock); #1;
    rst = 1'b1;
    model_reset();
    rom[0] = 8'h40; rom[1] = 8'h90; rom[2] = 8'hA0;  // B=A; OUT B -> expects 0
    run_prog(10);

    // Random programs.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      do_reset();
      run_prog(40);
    end

    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tw_core.md
TW_CORE -- requirements
Module: tw_core

Interface
REQ-001 Parameter DATA_W, default 4, register/immediate/IO width (>=4).
REQ-002 Parameter ADDR_W, default 4, program address width (1..DATA_W).
REQ-003 Port clock  input  1  sole clock, all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 Port addr  output  ADDR_W  program counter driven to instruction memory.
REQ-006 Port fetch_req  output  1  high while core waits for an instruction.
REQ-007 Port instr  input  4+DATA_W  instruction: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] imm.
REQ-008 Port instr_valid  input  1  instr valid for current addr.
REQ-009 Port in  input  DATA_W  general input port.
REQ-010 Port out  output  DATA_W  registered output port.
REQ-011 Port out_valid  output  1  one-cycle strobe on each out write.
REQ-012 Port halted  output  1  high while in HALT state.

Function
REQ-013 State machine SHALL have states FETCH, EXEC, HALT; reset enters FETCH.
REQ-014 FETCH: fetch_req=1, addr=pc; on instr_valid=1 latch instr into IR, go EXEC; else stay.
REQ-015 instr_valid SHALL be ignored outside FETCH.
REQ-016 EXEC lasts exactly one cycle; minimum 2 cycles/instruction; then FETCH, or HALT for HALT opcode.
REQ-017 Opcodes: 0000 A=A+imm, 0001 A=B, 0010 A=in, 0011 A=imm, 0100 B=A, 0101 B=B+imm, 0110 B=in, 0111 B=imm.
REQ-018 Opcodes: 1000 A=A+B, 1001 out=B, 1010 HALT, 1011 out=imm, 1100 JC imm, 1101 NOP, 1110 JMP imm, 1111 JNC imm.
REQ-019 Adds SHALL be DATA_W+1 bit, low DATA_W bits to destination, MSB to carry C.
REQ-020 Every executed non-add opcode SHALL clear C; adds set C from carry-out.
REQ-021 JC/JNC test C as held before the executing instruction; JC jumps on C=1, JNC on C=0.
REQ-022 Jump target = imm[ADDR_W-1:0]; non-taken/non-jump: pc=pc+1 modulo 2^ADDR_W (wraps max->0).
REQ-023 in SHALL be sampled in the EXEC cycle only.
REQ-024 out and out_valid update at end of EXEC; out_valid=1 for exactly one cycle per OUT op, else 0; out holds value.
REQ-025 HALT: pc, A, B, C, out frozen; fetch_req=0; halted=1; only reset exits.

Reset
REQ-026 reset=0 at a clock edge SHALL force pc=0, A=0, B=0, C=0, IR=0, out=0, out_valid=0, halted=0, state FETCH.
REQ-027 Reset SHALL win over any concurrent fetch, execute or halt, including mid-EXEC (no partial write).
REQ-028 No output SHALL change asynchronously to clock.

Structure
REQ-029 Opcode enum (4 bit) and state enum SHALL live in the shared types package.
REQ-030 One sub-module tw_alu (parametrised DATA_W adder, operands + carry-out) SHALL be instantiated.
REQ-031 Decode and FSM SHALL stay in tw_core; no other sub-modules.

Verification (DATA_W=4, ADDR_W=4)
REQ-032 Reset, ROM 0011_0101 (A=5), 0000_1100 (A+=12) -> A=1, C=1 after second EXEC.
REQ-033 ROM 0111_0011, 1001_0000 -> out=3, out_valid single-cycle pulse, out holds 3 afterwards.
REQ-034 instr_valid held low 5 cycles in FETCH -> fetch_req stays 1, addr constant, no state change.
REQ-035 pc=15 executing NOP -> next addr=0; JNC 0100 after add with C=1 -> not taken, addr=pc+1.
REQ-036 HALT at addr 2 -> halted=1, fetch_req=0, addr=2 frozen 10 cycles; reset=0 -> addr=0, halted=0.
REQ-037 reset=0 during EXEC of A=imm 9 -> A=0 after edge, state FETCH, addr=0.
